// File: rtl/ddr_link_pkg.sv
// Definitions shared by the game-state sender and data_receiver: word geometry,
// section order of a frame and the control-word bit layout.
package ddr_link_pkg;

    localparam int WORD_WIDTH          = 16;
    localparam int STATUS_BYTES        = 4;
    localparam int NUM_ARROWS_PER_TYPE = 4;

    localparam int PAUSE_BIT = 8;
    localparam int NEXT_BIT  = 0;

    typedef enum logic [1:0] {
        SEC_CTRL   = 2'd0,
        SEC_SCORE  = 2'd1,
        SEC_STATUS = 2'd2,
        SEC_ARROWS = 2'd3
    } section_e;

    // Only the pause and next-song bits may be set in a control word.
    function automatic logic ctrl_word_bad(input logic [WORD_WIDTH-1:0] word);
        logic [WORD_WIDTH-1:0] mask;
        mask            = '0;
        mask[PAUSE_BIT] = 1'b1;
        mask[NEXT_BIT]  = 1'b1;
        return |(word & ~mask);
    endfunction

endpackage

// File: rtl/frame_shadow_regs.sv
// Shadow registers that collect a frame word by word, and the output registers
// that take the whole frame in one cycle on commit.
module frame_shadow_regs
    import ddr_link_pkg::*;
#(
    parameter int WORD_WIDTH  = ddr_link_pkg::WORD_WIDTH,
    parameter int STAT_WORDS  = ddr_link_pkg::STATUS_BYTES / 2,
    parameter int ARROW_WORDS = 4 * ddr_link_pkg::NUM_ARROWS_PER_TYPE,
    parameter int STAT_W      = 1,
    parameter int AR_W        = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              wr_ctrl,
    input  logic                              wr_score,
    input  logic                              wr_status,
    input  logic                              wr_arrow,
    input  logic [STAT_W-1:0]                 stat_idx,
    input  logic [AR_W-1:0]                   ar_idx,
    input  logic [WORD_WIDTH-1:0]             wdata,
    input  logic                              commit,
    output logic                              pause,
    output logic                              next_song,
    output logic [WORD_WIDTH-1:0]             score,
    output logic [STAT_WORDS*WORD_WIDTH-1:0]  status,
    output logic [ARROW_WORDS*WORD_WIDTH-1:0] arrows
);

    logic                              sh_pause_q,  sh_pause_d;
    logic                              sh_next_q,   sh_next_d;
    logic [WORD_WIDTH-1:0]             sh_score_q,  sh_score_d;
    logic [STAT_WORDS*WORD_WIDTH-1:0]  sh_status_q, sh_status_d;
    logic [ARROW_WORDS*WORD_WIDTH-1:0] sh_arrows_q, sh_arrows_d;

    // Commit loads the _d values so the word written on the commit cycle lands too.
    always_comb begin
        sh_pause_d  = sh_pause_q;
        sh_next_d   = sh_next_q;
        sh_score_d  = sh_score_q;
        sh_status_d = sh_status_q;
        sh_arrows_d = sh_arrows_q;
        if (clear) begin
            sh_pause_d  = 1'b0;
            sh_next_d   = 1'b0;
            sh_score_d  = '0;
            sh_status_d = '0;
            sh_arrows_d = '0;
        end else begin
            if (wr_ctrl) begin
                sh_pause_d = wdata[PAUSE_BIT];
                sh_next_d  = wdata[NEXT_BIT];
            end
            if (wr_score) begin
                sh_score_d = wdata;
            end
            for (int k = 0; k < STAT_WORDS; k++) begin
                if (wr_status && int'(stat_idx) == k) begin
                    sh_status_d[(STAT_WORDS-1-k)*WORD_WIDTH +: WORD_WIDTH] = wdata;
                end
            end
            for (int k = 0; k < ARROW_WORDS; k++) begin
                if (wr_arrow && int'(ar_idx) == k) begin
                    sh_arrows_d[(ARROW_WORDS-1-k)*WORD_WIDTH +: WORD_WIDTH] = wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_pause_q  <= 1'b0;
            sh_next_q   <= 1'b0;
            sh_score_q  <= '0;
            sh_status_q <= '0;
            sh_arrows_q <= '0;
            pause       <= 1'b0;
            next_song   <= 1'b0;
            score       <= '0;
            status      <= '0;
            arrows      <= '0;
        end else begin
            sh_pause_q  <= sh_pause_d;
            sh_next_q   <= sh_next_d;
            sh_score_q  <= sh_score_d;
            sh_status_q <= sh_status_d;
            sh_arrows_q <= sh_arrows_d;
            if (commit) begin
                pause     <= sh_pause_d;
                next_song <= sh_next_d;
                score     <= sh_score_d;
                status    <= sh_status_d;
                arrows    <= sh_arrows_d;
            end
        end
    end

endmodule

// File: rtl/data_receiver.sv
// Receive side of the game-state link: rebuilds one frame from the 16-bit word
// stream and commits it atomically. Optional inter-word timeout: FRAME_TIMEOUT_EN.
module data_receiver
    import ddr_link_pkg::*;
#(
    parameter int WORD_WIDTH          = ddr_link_pkg::WORD_WIDTH,
    parameter int STATUS_BYTES        = ddr_link_pkg::STATUS_BYTES,
    parameter int NUM_ARROWS_PER_TYPE = ddr_link_pkg::NUM_ARROWS_PER_TYPE,
    parameter int TIMEOUT_CYCLES      = 1000
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start_recv,
    input  logic [WORD_WIDTH-1:0]                        in_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    output logic                                         pause,
    output logic                                         next_song,
    output logic [WORD_WIDTH-1:0]                        score,
    output logic [STATUS_BYTES*8-1:0]                    status,
    output logic [4*NUM_ARROWS_PER_TYPE*WORD_WIDTH-1:0]  arrows,
    output logic                                         frame_valid,
    output logic                                         frame_err,
    output logic                                         busy
);

    // state    | meaning
    // IDLE     | no frame in progress, waiting for start_recv
    // CTRL     | expecting the control word (pause / next-song)
    // SCORE    | expecting the score word
    // STATUS   | expecting status words, two bytes each
    // ARROWS   | expecting arrow words
    // DONE     | one cycle: outputs committed or frame discarded
    localparam logic [2:0] S_CTRL   = {1'b0, SEC_CTRL};
    localparam logic [2:0] S_SCORE  = {1'b0, SEC_SCORE};
    localparam logic [2:0] S_STATUS = {1'b0, SEC_STATUS};
    localparam logic [2:0] S_ARROWS = {1'b0, SEC_ARROWS};
    localparam logic [2:0] S_IDLE   = 3'b100;
    localparam logic [2:0] S_DONE   = 3'b101;

    localparam int STAT_WORDS  = STATUS_BYTES / 2;
    localparam int ARROW_WORDS = 4 * NUM_ARROWS_PER_TYPE;
    localparam int STAT_W      = (STAT_WORDS  > 1) ? $clog2(STAT_WORDS)  : 1;
    localparam int AR_W        = (ARROW_WORDS > 1) ? $clog2(ARROW_WORDS) : 1;
    localparam logic [STAT_W-1:0] STAT_LAST = STAT_W'(STAT_WORDS - 1);
    localparam logic [AR_W-1:0]   AR_LAST   = AR_W'(ARROW_WORDS - 1);

    logic [2:0]        state_q, state_d;
    logic [STAT_W-1:0] stat_cnt_q, stat_cnt_d;
    logic [AR_W-1:0]   ar_cnt_q, ar_cnt_d;
    logic              err_q, err_d;
    logic              in_ready_q, frame_valid_q, frame_err_q;
    logic              xfer, timeout_hit;
    logic              wr_ctrl, wr_score, wr_status, wr_arrow;
    logic              clear, commit, discard;

    assign busy        = (state_q != S_IDLE);
    assign in_ready    = in_ready_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

    // A start pulse or a timeout on the same cycle swallows the offered word.
    assign xfer = in_valid && in_ready_q && !start_recv && !timeout_hit;

`ifdef FRAME_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap_q;

    assign timeout_hit = busy && !start_recv && (gap_q == GAP_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else if (!busy || start_recv || timeout_hit || xfer) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        stat_cnt_d = stat_cnt_q;
        ar_cnt_d   = ar_cnt_q;
        err_d      = err_q;
        wr_ctrl    = 1'b0;
        wr_score   = 1'b0;
        wr_status  = 1'b0;
        wr_arrow   = 1'b0;
        clear      = 1'b0;
        commit     = 1'b0;
        discard    = 1'b0;
        if (start_recv) begin
            state_d    = S_CTRL;
            stat_cnt_d = '0;
            ar_cnt_d   = '0;
            err_d      = 1'b0;
            clear      = 1'b1;
        end else if (timeout_hit) begin
            state_d    = S_IDLE;
            stat_cnt_d = '0;
            ar_cnt_d   = '0;
            err_d      = 1'b0;
            clear      = 1'b1;
            discard    = 1'b1;
        end else begin
            case (state_q)
                S_CTRL: if (xfer) begin
                    wr_ctrl = 1'b1;
                    if (ctrl_word_bad(in_data)) err_d = 1'b1;
                    state_d = S_SCORE;
                end
                S_SCORE: if (xfer) begin
                    wr_score = 1'b1;
                    state_d  = S_STATUS;
                end
                S_STATUS: if (xfer) begin
                    wr_status = 1'b1;
                    if (stat_cnt_q == STAT_LAST) begin
                        stat_cnt_d = '0;
                        state_d    = S_ARROWS;
                    end else begin
                        stat_cnt_d = stat_cnt_q + 1'b1;
                    end
                end
                // Commit/discard is decided with the last word so the pulse
                // and the new outputs appear together during DONE.
                S_ARROWS: if (xfer) begin
                    wr_arrow = 1'b1;
                    if (ar_cnt_q == AR_LAST) begin
                        ar_cnt_d = '0;
                        state_d  = S_DONE;
                        commit   = !err_q;
                        discard  = err_q;
                    end else begin
                        ar_cnt_d = ar_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            stat_cnt_q    <= '0;
            ar_cnt_q      <= '0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            stat_cnt_q    <= stat_cnt_d;
            ar_cnt_q      <= ar_cnt_d;
            err_q         <= err_d;
            in_ready_q    <= (state_d != S_IDLE) && (state_d != S_DONE);
            frame_valid_q <= commit;
            frame_err_q   <= discard;
        end
    end

    frame_shadow_regs #(
        .WORD_WIDTH  (WORD_WIDTH),
        .STAT_WORDS  (STAT_WORDS),
        .ARROW_WORDS (ARROW_WORDS),
        .STAT_W      (STAT_W),
        .AR_W        (AR_W)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .wr_ctrl   (wr_ctrl),
        .wr_score  (wr_score),
        .wr_status (wr_status),
        .wr_arrow  (wr_arrow),
        .stat_idx  (stat_cnt_q),
        .ar_idx    (ar_cnt_q),
        .wdata     (in_data),
        .commit    (commit),
        .pause     (pause),
        .next_song (next_song),
        .score     (score),
        .status    (status),
        .arrows    (arrows)
    );

endmodule
